reg_dump_reader: RTL and testbench

Reads the register-dump region of data memory, the 32 words that the CPU stores at `BASE_ADDR + rd` when it spills a register for display. Converts each word to ASCII hex and streams the characters with row/column coordinates to the VGA text buffer. The block sits beside the CPU on the shared memory port and borrows the port through a request/grant handshake with the memory-source arbiter. It is the consumer end of the CPU's dump-for-VGA write path.

---
 rtl/reg_dump_reader.sv | 131 +++++++++++++
 tb/tb_reg_dump_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Scans the register-dump slots in data memory and streams each word as
// uppercase ASCII hex characters, tagged with row/column, to the VGA text buffer.
module reg_dump_reader #(
  parameter int WORD_SIZE  = 32,
  parameter int BASE_ADDR  = 480,
  parameter int NUM_REGS   = 32,
  parameter int HEX_DIGITS = WORD_SIZE / 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_req,
  input  logic                          mem_grant,
  output logic [WORD_SIZE-1:0]          mem_addr,
  input  logic [WORD_SIZE-1:0]          mem_read_data,
  output logic                          char_valid,
  input  logic                          char_ready,
  output logic [7:0]                    char_data,
  output logic [4:0]                    char_row,
  output logic [$clog2(HEX_DIGITS)-1:0] char_col
);

  localparam int COL_W = $clog2(HEX_DIGITS);
  localparam int IDX_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_CAP,
    S_EMIT,
    S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [WORD_SIZE-1:0] word_q, word_d;
  logic [3:0]           nibble;
  logic [WORD_SIZE-1:0] slot_addr;

  assign nibble    = word_q[WORD_SIZE-1 -: 4];
  assign slot_addr = WORD_SIZE'(BASE_ADDR) + WORD_SIZE'(idx_q);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      col_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    col_d      = col_q;
    word_d     = word_q;
    busy       = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    char_valid = 1'b0;
    char_data  = '0;
    char_row   = '0;
    char_col   = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          idx_d   = '0;
          col_d   = '0;
        end
      end
      S_REQ: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = slot_addr;
        if (mem_grant) state_d = S_RD;
      end
      S_RD: begin
        // A grant lost here means the read never issued; retry the same slot.
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = slot_addr;
        state_d  = mem_grant ? S_CAP : S_REQ;
      end
      S_CAP: begin
        busy    = 1'b1;
        word_d  = mem_read_data;
        col_d   = '0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        busy       = 1'b1;
        char_valid = 1'b1;
        char_data  = (nibble < 4'd10) ? 8'h30 + {4'h0, nibble}
                                      : 8'h37 + {4'h0, nibble};
        char_row   = idx_q;
        char_col   = col_q;
        if (char_ready) begin
          word_d = word_q << 4;
          if (col_q == COL_W'(HEX_DIGITS - 1)) begin
            col_d = '0;
            if (idx_q == IDX_W'(NUM_REGS - 1)) begin
              state_d = S_FIN;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_REQ;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: memory model, randomized grant/ready, and a
// scoreboard of expected characters derived from formatted hex strings.
module tb_reg_dump_reader;

  localparam int BASE = 480;
  localparam int NREG = 32;
  localparam int HD   = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        mem_grant = 1'b0;
  logic        char_ready = 1'b0;
  logic        busy, done, mem_req, char_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_read_data = '0;
  logic [7:0]  char_data;
  logic [4:0]  char_row;
  logic [2:0]  char_col;

  always #5 clk = ~clk;

  reg_dump_reader #(
    .WORD_SIZE (32),
    .BASE_ADDR (BASE),
    .NUM_REGS  (NREG),
    .HEX_DIGITS(HD)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .mem_req      (mem_req),
    .mem_grant    (mem_grant),
    .mem_addr     (mem_addr),
    .mem_read_data(mem_read_data),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .char_data    (char_data),
    .char_row     (char_row),
    .char_col     (char_col)
  );

  logic [31:0] mem [0:1023];

  // Synchronous read port; junk when no granted address so a mistimed capture shows.
  always @(posedge clk)
    mem_read_data <= (mem_req && mem_grant) ? mem[mem_addr[9:0]] : $urandom;

  typedef struct {
    int  row;
    int  col;
    byte ch;
  } exp_t;

  exp_t exq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   gmode = 0;      // 0 high, 1 random, 2 withhold at 483, 3 drop RD at 487
  int   rmode = 0;      // 0 high, 1 random, 2 stall at row 0 col 2
  int   cyc = 0, busy_rise = -1, done_cyc = -1, done_cnt = 0, char_cnt = 0;
  int   run_len = 0, stall_cnt = 0;
  logic [31:0] last_addr = '0;
  logic prev_req = 1'b0, prev_stall = 1'b0, prev_busy = 1'b0;
  logic [7:0] st_data;
  logic [4:0] st_row;
  logic [2:0] st_col;
  byte  obs [0:31][0:7];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_expected();
    string s;
    exq.delete();
    for (int r = 0; r < NREG; r++) begin
      s = $sformatf("%08h", mem[BASE + r]);
      s = s.toupper();
      for (int c = 0; c < HD; c++) exq.push_back('{r, c, s[c]});
    end
  endtask

  always @(negedge clk) begin
    int   exp_len;
    exp_t e;
    cyc++;
    case (gmode)
      0:       mem_grant = 1'b1;
      1:       mem_grant = ($urandom_range(0, 2) != 0);
      2:       mem_grant = !(mem_req && mem_addr == 32'd483 && run_len < 5);
      default: mem_grant = !(mem_req && mem_addr == 32'd487 && run_len == 1);
    endcase
    case (rmode)
      0: char_ready = 1'b1;
      1: char_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (char_valid && char_row == 5'd0 && char_col == 3'd2 && stall_cnt < 4) begin
          char_ready = 1'b0;
          stall_cnt++;
          check("stall_data", char_data, 8'h30);
        end else char_ready = 1'b1;
      end
    endcase
    if (resetn) begin
      if (prev_stall) begin
        check("hold_valid", char_valid, 1'b1);
        check("hold_data", char_data, st_data);
        check("hold_row", char_row, st_row);
        check("hold_col", char_col, st_col);
      end
      prev_stall = char_valid && !char_ready;
      st_data = char_data;
      st_row  = char_row;
      st_col  = char_col;
      if (mem_req) begin
        if (exq.size() == 0) check("spurious_req", 1, 0);
        else check("mem_addr", mem_addr, 64'(BASE + exq[0].row));
        run_len++;
        last_addr = mem_addr;
      end else begin
        check("addr_idle", mem_addr, 0);
        if (prev_req && gmode != 1) begin
          exp_len = 2;
          if (gmode == 2 && last_addr == 32'd483) exp_len = 7;
          if (gmode == 3 && last_addr == 32'd487) exp_len = 4;
          check("req_len", run_len, exp_len);
        end
        run_len = 0;
      end
      prev_req = mem_req;
      if (char_valid && char_ready) begin
        if (exq.size() == 0) check("char_unexpected", 1, 0);
        else begin
          e = exq.pop_front();
          check("char_row", char_row, e.row);
          check("char_col", char_col, e.col);
          check("char_data", char_data, e.ch);
          obs[char_row][char_col] = char_data;
          char_cnt++;
        end
      end
      if (busy && !prev_busy) busy_rise = cyc;
      prev_busy = busy;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_queue_empty", exq.size(), 0);
      end
    end else begin
      prev_stall = 1'b0;
      prev_req   = 1'b0;
      prev_busy  = 1'b0;
      run_len    = 0;
    end
  end

  function automatic logic [63:0] row_word(input int r);
    logic [63:0] w = '0;
    for (int c = 0; c < HD; c++) w = {w[55:0], obs[r][c]};
    return w;
  endfunction

  task automatic run_dump(input int gm, input int rm, input int budget);
    int t = 0;
    gmode = gm;
    rmode = rm;
    stall_cnt = 0;
    char_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    busy_rise = -1;
    load_expected();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_req", mem_req, 1'b1);
    check("start_addr", mem_addr, 32'd480);
    while (done_cnt == 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("done_in_budget", (t < budget), 1'b1);
    repeat (2) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("char_total", char_cnt, NREG * HD);
    check("busy_after", busy, 1'b0);
  endtask

  initial begin
    int t;
    // Reset with start pulsed inside it
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = (i == 1);
      check("rst_outputs", {busy, done, mem_req, char_valid, mem_addr, char_data, char_row, char_col}, '0);
    end
    @(negedge clk) begin
      start  = 1'b0;
      resetn = 1'b1;
    end
    repeat (2) @(negedge clk);
    check("idle_after_rst", {busy, mem_req}, '0);

    // Full dump with nibble values wrapping through 0..F
    for (int i = 0; i < NREG; i++) mem[BASE + i] = (i % 16) * 32'h1111_1111;
    run_dump(0, 0, 1000);
    check("done_latency", done_cyc - busy_rise, 352);
    check("row5", row_word(5), 64'h3535353535353535);
    check("row15", row_word(15), 64'h4646464646464646);
    check("row31", row_word(31), 64'h4646464646464646);

    // Grant withheld at idx 3, then grant dropped in RD at idx 7
    for (int i = 0; i < NREG; i++) mem[BASE + i] = $urandom;
    run_dump(2, 0, 1500);
    for (int i = 0; i < NREG; i++) mem[BASE + i] = $urandom;
    run_dump(3, 0, 1500);

    // Backpressure on word 0x000000AF
    mem[BASE] = 32'h0000_00AF;
    run_dump(0, 2, 1500);
    check("stall_cycles", stall_cnt, 4);
    check("row0_af", row_word(0), 64'h3030303030304146);

    // Randomized grant and ready
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NREG; i++) mem[BASE + i] = $urandom;
      run_dump(1, 1, 6000);
    end

    // Mid-dump start ignored, then abort by reset at idx 10
    for (int i = 0; i < NREG; i++) mem[BASE + i] = $urandom;
    gmode = 0;
    rmode = 0;
    done_cnt = 0;
    load_expected();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t = 0;
    while (!(char_valid && char_row == 5'd4) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("reach_row4", (t < 2000), 1'b1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("mid_start_busy", busy, 1'b1);
    t = 0;
    while (!(char_valid && char_row == 5'd10) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("reach_row10", (t < 2000), 1'b1);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_outputs", {busy, done, mem_req, char_valid}, '0);
    resetn = 1'b1;
    exq.delete();
    repeat (5) @(negedge clk);
    check("abort_idle", {busy, mem_req}, '0);
    check("abort_no_done", done_cnt, 0);
    for (int i = 0; i < NREG; i++) mem[BASE + i] = $urandom;
    run_dump(0, 0, 1000);
    check("restart_row0", row_word(0), 64'(0) | {obs[0][0], obs[0][1], obs[0][2], obs[0][3],
                                                 obs[0][4], obs[0][5], obs[0][6], obs[0][7]});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
